// File: rtl/decodificador_bcd_to_seg7.sv
// Six-digit keypad entry display driver.
// Accepted BCD digits shift into a six-position register (newest in position 1)
// and every position is decoded to an active-low {g,f,e,d,c,b,a} segment pattern.
module decodificador_bcd_to_seg7 (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] bcd_in,
    input  logic       key_valid,
    output logic [6:0] bcd1,
    output logic [6:0] bcd2,
    output logic [6:0] bcd3,
    output logic [6:0] bcd4,
    output logic [6:0] bcd5,
    output logic [6:0] bcd6
);

    localparam int unsigned NumPos = 6;

    // Active-low segment patterns, bit order {g,f,e,d,c,b,a}.
    localparam logic [6:0] Seg0     = 7'b1000000;
    localparam logic [6:0] Seg1     = 7'b1111001;
    localparam logic [6:0] Seg2     = 7'b0100100;
    localparam logic [6:0] Seg3     = 7'b0110000;
    localparam logic [6:0] Seg4     = 7'b0011001;
    localparam logic [6:0] Seg5     = 7'b0010010;
    localparam logic [6:0] Seg6     = 7'b0000010;
    localparam logic [6:0] Seg7     = 7'b1111000;
    localparam logic [6:0] Seg8     = 7'b0000000;
    localparam logic [6:0] Seg9     = 7'b0010000;
    localparam logic [6:0] SegBlank = 7'b1111111;

    // Index 0 holds position 1 (newest), index 5 holds position 6 (oldest).
    logic [3:0] digit_q [NumPos];
    logic [3:0] digit_d [NumPos];
    logic [NumPos-1:0] used_q;
    logic [NumPos-1:0] used_d;

    logic digit_legal;
    logic accept;

    logic [6:0] seg [NumPos];

    // Decode a stored position to segments; unused positions are blank.
    function automatic logic [6:0] seg7_encode(input logic [3:0] value, input logic used);
        logic [6:0] pattern;
        case (value)
            4'd0:    pattern = Seg0;
            4'd1:    pattern = Seg1;
            4'd2:    pattern = Seg2;
            4'd3:    pattern = Seg3;
            4'd4:    pattern = Seg4;
            4'd5:    pattern = Seg5;
            4'd6:    pattern = Seg6;
            4'd7:    pattern = Seg7;
            4'd8:    pattern = Seg8;
            4'd9:    pattern = Seg9;
            default: pattern = SegBlank;
        endcase
        if (!used) begin
            pattern = SegBlank;
        end
        return pattern;
    endfunction

    // Qualify the keypad strobe: only codes 0-9 are accepted, level-sensitive.
    always_comb begin
        digit_legal = (bcd_in <= 4'd9);
        accept      = key_valid && digit_legal;
    end

    // Next state: shift one position toward the oldest slot on accept, else hold.
    always_comb begin
        for (int k = 0; k < NumPos; k++) begin
            digit_d[k] = digit_q[k];
        end
        used_d = used_q;
        if (accept) begin
            for (int k = NumPos - 1; k > 0; k--) begin
                digit_d[k] = digit_q[k-1];
            end
            digit_d[0] = bcd_in;
            used_d     = {used_q[NumPos-2:0], 1'b1};
        end
    end

    // Digit values; reset clears to zero immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < NumPos; k++) begin
                digit_q[k] <= 4'd0;
            end
        end else begin
            for (int k = 0; k < NumPos; k++) begin
                digit_q[k] <= digit_d[k];
            end
        end
    end

    // Occupancy flags; reset marks every position blank.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            used_q <= '0;
        end else begin
            used_q <= used_d;
        end
    end

    // Decode every position purely from stored state.
    always_comb begin
        for (int k = 0; k < NumPos; k++) begin
            seg[k] = seg7_encode(digit_q[k], used_q[k]);
        end
    end

    // Map decoded positions onto the display outputs.
    always_comb begin
        bcd1 = seg[0];
        bcd2 = seg[1];
        bcd3 = seg[2];
        bcd4 = seg[3];
        bcd5 = seg[4];
        bcd6 = seg[5];
    end

endmodule

// File: tb/tb_decodificador_bcd_to_seg7.sv
// Directed self-checking bench for the six-digit seven-segment driver.
module tb_decodificador_bcd_to_seg7;

    localparam logic [6:0] S0 = 7'b1000000;
    localparam logic [6:0] S1 = 7'b1111001;
    localparam logic [6:0] S2 = 7'b0100100;
    localparam logic [6:0] S3 = 7'b0110000;
    localparam logic [6:0] S4 = 7'b0011001;
    localparam logic [6:0] S5 = 7'b0010010;
    localparam logic [6:0] S6 = 7'b0000010;
    localparam logic [6:0] S7 = 7'b1111000;
    localparam logic [6:0] S8 = 7'b0000000;
    localparam logic [6:0] S9 = 7'b0010000;
    localparam logic [6:0] BL = 7'b1111111;

    logic       clk;
    logic       rst;
    logic [3:0] bcd_in;
    logic       key_valid;
    logic [6:0] bcd1, bcd2, bcd3, bcd4, bcd5, bcd6;

    int errors;
    int checks;

    decodificador_bcd_to_seg7 dut (
        .clk       (clk),
        .rst       (rst),
        .bcd_in    (bcd_in),
        .key_valid (key_valid),
        .bcd1      (bcd1),
        .bcd2      (bcd2),
        .bcd3      (bcd3),
        .bcd4      (bcd4),
        .bcd5      (bcd5),
        .bcd6      (bcd6)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [6:0] obs, input logic [6:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic [6:0] e1, input logic [6:0] e2,
                             input logic [6:0] e3, input logic [6:0] e4,
                             input logic [6:0] e5, input logic [6:0] e6);
        check({tag, ".bcd1"}, bcd1, e1);
        check({tag, ".bcd2"}, bcd2, e2);
        check({tag, ".bcd3"}, bcd3, e3);
        check({tag, ".bcd4"}, bcd4, e4);
        check({tag, ".bcd5"}, bcd5, e5);
        check({tag, ".bcd6"}, bcd6, e6);
    endtask

    // Drive inputs at the falling edge, sample just after the next rising edge.
    task automatic step(input logic [3:0] d, input logic kv);
        @(negedge clk);
        bcd_in    = d;
        key_valid = kv;
        @(posedge clk);
        #1;
    endtask

    initial begin
        errors    = 0;
        checks    = 0;
        rst       = 1'b1;
        bcd_in    = 4'd0;
        key_valid = 1'b0;

        // Reset state before and after the first edge.
        #2;
        check_all("reset_pre_edge", BL, BL, BL, BL, BL, BL);
        @(posedge clk);
        #1;
        check_all("reset_post_edge", BL, BL, BL, BL, BL, BL);

        // Reset wins over a simultaneous legal key.
        step(4'd5, 1'b1);
        check_all("reset_wins", BL, BL, BL, BL, BL, BL);

        @(negedge clk);
        rst       = 1'b0;
        key_valid = 1'b0;

        // Hold key_valid high across five digits: one shift per edge.
        step(4'd1, 1'b1);
        check_all("latency_first", S1, BL, BL, BL, BL, BL);
        step(4'd2, 1'b1);
        step(4'd3, 1'b1);
        step(4'd4, 1'b1);
        step(4'd5, 1'b1);
        check_all("five_digits", S5, S4, S3, S2, S1, BL);
        for (int i = 0; i < 3; i++) begin
            step(4'd8, 1'b0);
        end
        check_all("five_hold", S5, S4, S3, S2, S1, BL);

        // Ten digits through a six-slot register: oldest ones fall off.
        for (int i = 0; i < 10; i++) begin
            step(4'(i), 1'b1);
        end
        check_all("zero_to_nine", S9, S8, S7, S6, S5, S4);

        step(4'd7, 1'b1);
        check_all("enter_seven", S7, S9, S8, S7, S6, S5);

        // Illegal codes with key_valid high are ignored.
        for (int i = 10; i < 16; i++) begin
            step(4'(i), 1'b1);
            check($sformatf("illegal_%0d.bcd1", i), bcd1, S7);
        end
        check_all("illegal_all", S7, S9, S8, S7, S6, S5);

        // key_valid low with bcd_in toggling: nothing moves.
        for (int i = 0; i < 10; i++) begin
            step((i % 2 == 0) ? 4'd3 : 4'd6, 1'b0);
            check($sformatf("idle_%0d.bcd1", i), bcd1, S7);
        end
        check_all("idle_all", S7, S9, S8, S7, S6, S5);

        // Asynchronous reset mid-sequence, checked before any edge.
        step(4'd1, 1'b1);
        step(4'd2, 1'b1);
        step(4'd3, 1'b1);
        check_all("three_more", S3, S2, S1, S7, S9, S8);
        @(negedge clk);
        key_valid = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        check_all("async_reset", BL, BL, BL, BL, BL, BL);
        @(negedge clk);
        rst = 1'b0;
        step(4'd8, 1'b1);
        check_all("after_reset", S8, BL, BL, BL, BL, BL);
        step(4'd0, 1'b0);
        check_all("after_reset_hold", S8, BL, BL, BL, BL, BL);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
